fix_seq_session_ctrl: RTL and testbench

Session-level sequence controller for the FIX receive path.
- Takes one decoded header event per parsed inbound message and compares its MsgSeqNum with the expected number held by sequence_generator.
- Decides per message: accept, ignore, gap recovery or fatal.
- Drives the generator's advance and load controls.
- Issues ResendRequest and Logout requests to the outbound message builder.

---
 rtl/fix_session_pkg.sv | 32 +++
 rtl/fix_seq_session_ctrl.sv | 176 +++++++++++++++++
 tb/tb_fix_seq_session_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/fix_session_pkg.sv
// Shared definitions for the FIX receive-path session sequence controller:
// MsgType codes, FSM state encoding, decision pulse bundle and width defaults.
package fix_session_pkg;

  localparam int SEQ_W_DEF = 8;
  localparam int MT_W_DEF  = 4;

  localparam logic [MT_W_DEF-1:0] MT_LOGON      = 4'd0;
  localparam logic [MT_W_DEF-1:0] MT_LOGOUT     = 4'd1;
  localparam logic [MT_W_DEF-1:0] MT_SEQ_RESET  = 4'd2;
  localparam logic [MT_W_DEF-1:0] MT_RESEND_REQ = 4'd3;
  localparam logic [MT_W_DEF-1:0] MT_HEARTBEAT  = 4'd4;
  localparam logic [MT_W_DEF-1:0] MT_APP        = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACTIVE  = 3'd1,
    ST_RSD_REQ = 3'd2,
    ST_RECOVER = 3'd3,
    ST_FATAL   = 3'd4
  } state_e;

  typedef struct packed {
    logic advance;
    logic load;
    logic accept;
    logic ignore;
    logic logout;
    logic reject;
  } pulse_t;

endpackage

// File: rtl/fix_seq_session_ctrl.sv
// Session sequence controller: one header event in, one registered decision out
// the cycle after capture; drives generator advance/load, ResendRequest and Logout.
module fix_seq_session_ctrl
  import fix_session_pkg::*;
#(
  parameter int SEQ_W = SEQ_W_DEF,
  parameter int MT_W  = MT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hdr_valid_i,
  output logic             hdr_ready_o,
  input  logic [MT_W-1:0]  msg_type_i,
  input  logic [SEQ_W-1:0] msg_seq_num_i,
  input  logic             poss_dup_i,
  input  logic             gap_fill_i,
  input  logic [SEQ_W-1:0] new_seq_num_i,
  input  logic             session_reset_i,
  input  logic [SEQ_W-1:0] expected_seq_i,
  output logic             seq_advance_o,
  output logic             seq_load_o,
  output logic [SEQ_W-1:0] seq_load_val_o,
  output logic             msg_accept_o,
  output logic             msg_ignore_o,
  output logic             rsd_valid_o,
  input  logic             rsd_ready_i,
  output logic [SEQ_W-1:0] rsd_begin_o,
  output logic [SEQ_W-1:0] rsd_end_o,
  output logic             logout_req_o,
  output logic             reject_o,
  output logic [2:0]       state_o
);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [MT_W-1:0]  mt_q, mt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [SEQ_W-1:0] new_q, new_d;
  logic             pd_q, pd_d;
  logic             gf_q, gf_d;
  logic [SEQ_W-1:0] gap_begin_q, gap_begin_d;
  logic [SEQ_W-1:0] gap_end_q, gap_end_d;
  pulse_t           pulse_q, pulse_d;
  logic [SEQ_W-1:0] load_val_q, load_val_d;

  logic in_rec;
  logic is_seq_reset;
  logic take;

  assign hdr_ready_o  = !pend_q && (state_q != ST_RSD_REQ);
  assign take         = hdr_valid_i && hdr_ready_o;
  assign in_rec       = (state_q == ST_RECOVER);
  assign is_seq_reset = (mt_q == MT_W'(MT_SEQ_RESET));

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    mt_d        = mt_q;
    seq_d       = seq_q;
    new_d       = new_q;
    pd_d        = pd_q;
    gf_d        = gf_q;
    gap_begin_d = gap_begin_q;
    gap_end_d   = gap_end_q;
    pulse_d     = '0;
    load_val_d  = load_val_q;

    if (take) begin
      pend_d = 1'b1;
      mt_d   = msg_type_i;
      seq_d  = msg_seq_num_i;
      new_d  = new_seq_num_i;
      pd_d   = poss_dup_i;
      gf_d   = gap_fill_i;
    end

    if (state_q == ST_RSD_REQ) begin
      if (rsd_ready_i) state_d = ST_RECOVER;
    end else if (pend_q) begin
      pend_d = 1'b0;
      if (state_q == ST_FATAL || (state_q == ST_IDLE && mt_q != MT_W'(MT_LOGON))) begin
        pulse_d.ignore = 1'b1;
      end else begin
        // A Logon out of IDLE is judged by the ACTIVE rules in this same cycle
        if (state_q == ST_IDLE) state_d = ST_ACTIVE;
        if (is_seq_reset && !gf_q) begin
          if (new_q >= expected_seq_i) begin
            pulse_d.load   = 1'b1;
            pulse_d.accept = 1'b1;
            load_val_d     = new_q;
            if (in_rec) state_d = ST_ACTIVE;
          end else begin
            pulse_d.reject = 1'b1;
          end
        end else if (is_seq_reset && seq_q == expected_seq_i) begin
          if (new_q > expected_seq_i) begin
            pulse_d.load   = 1'b1;
            pulse_d.accept = 1'b1;
            load_val_d     = new_q;
            if (in_rec && new_q > gap_end_q) state_d = ST_ACTIVE;
          end else begin
            pulse_d.reject = 1'b1;
            pulse_d.ignore = 1'b1;
          end
        end else if (seq_q == expected_seq_i) begin
          pulse_d.accept  = 1'b1;
          pulse_d.advance = 1'b1;
          if (mt_q == MT_W'(MT_LOGOUT)) state_d = ST_IDLE;
          else if (in_rec && expected_seq_i == gap_end_q) state_d = ST_ACTIVE;
        end else if (seq_q > expected_seq_i) begin
          pulse_d.ignore = 1'b1;
          if (!in_rec) begin
            gap_begin_d = expected_seq_i;
            gap_end_d   = seq_q - SEQ_W'(1);
            state_d     = ST_RSD_REQ;
          end
        end else if (pd_q) begin
          pulse_d.ignore = 1'b1;
        end else begin
          pulse_d.logout = 1'b1;
          state_d        = ST_FATAL;
        end
      end
    end

    // Session reset overrides any decision or capture in the same cycle
    if (session_reset_i) begin
      state_d      = ST_IDLE;
      pend_d       = 1'b0;
      pulse_d      = '0;
      pulse_d.load = 1'b1;
      load_val_d   = SEQ_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= 1'b0;
      mt_q        <= '0;
      seq_q       <= '0;
      new_q       <= '0;
      pd_q        <= 1'b0;
      gf_q        <= 1'b0;
      gap_begin_q <= '0;
      gap_end_q   <= '0;
      pulse_q     <= '0;
      load_val_q  <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      mt_q        <= mt_d;
      seq_q       <= seq_d;
      new_q       <= new_d;
      pd_q        <= pd_d;
      gf_q        <= gf_d;
      gap_begin_q <= gap_begin_d;
      gap_end_q   <= gap_end_d;
      pulse_q     <= pulse_d;
      load_val_q  <= load_val_d;
    end
  end

  assign seq_advance_o  = pulse_q.advance;
  assign seq_load_o     = pulse_q.load;
  assign seq_load_val_o = load_val_q;
  assign msg_accept_o   = pulse_q.accept;
  assign msg_ignore_o   = pulse_q.ignore;
  assign logout_req_o   = pulse_q.logout;
  assign reject_o       = pulse_q.reject;
  assign rsd_valid_o    = (state_q == ST_RSD_REQ);
  assign rsd_begin_o    = gap_begin_q;
  assign rsd_end_o      = gap_end_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_fix_seq_session_ctrl.sv
// Scoreboard bench for fix_seq_session_ctrl: directed header events push expected
// decision pulses; a negedge monitor pops and compares whenever a pulse appears.
module tb_fix_seq_session_ctrl;
  import fix_session_pkg::*;

  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hdr_valid_i = 1'b0;
  logic          hdr_ready_o;
  logic [3:0]    msg_type_i = '0;
  logic [SW-1:0] msg_seq_num_i = '0;
  logic          poss_dup_i = 1'b0;
  logic          gap_fill_i = 1'b0;
  logic [SW-1:0] new_seq_num_i = '0;
  logic          session_reset_i = 1'b0;
  logic [SW-1:0] expected_seq_i;
  logic          seq_advance_o, seq_load_o, msg_accept_o, msg_ignore_o;
  logic [SW-1:0] seq_load_val_o, rsd_begin_o, rsd_end_o;
  logic          rsd_valid_o, logout_req_o, reject_o;
  logic          rsd_ready_i = 1'b0;
  logic [2:0]    state_o;

  fix_seq_session_ctrl #(.SEQ_W(SW), .MT_W(4)) dut (
    .clk(clk), .rst(rst),
    .hdr_valid_i(hdr_valid_i), .hdr_ready_o(hdr_ready_o),
    .msg_type_i(msg_type_i), .msg_seq_num_i(msg_seq_num_i),
    .poss_dup_i(poss_dup_i), .gap_fill_i(gap_fill_i),
    .new_seq_num_i(new_seq_num_i), .session_reset_i(session_reset_i),
    .expected_seq_i(expected_seq_i),
    .seq_advance_o(seq_advance_o), .seq_load_o(seq_load_o),
    .seq_load_val_o(seq_load_val_o),
    .msg_accept_o(msg_accept_o), .msg_ignore_o(msg_ignore_o),
    .rsd_valid_o(rsd_valid_o), .rsd_ready_i(rsd_ready_i),
    .rsd_begin_o(rsd_begin_o), .rsd_end_o(rsd_end_o),
    .logout_req_o(logout_req_o), .reject_o(reject_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  // pulse vector order: advance, load, accept, ignore, logout, reject
  localparam logic [5:0] P_ACC_ADV  = 6'b101000;
  localparam logic [5:0] P_IGN      = 6'b000100;
  localparam logic [5:0] P_LOAD_ACC = 6'b011000;
  localparam logic [5:0] P_REJ_IGN  = 6'b000101;
  localparam logic [5:0] P_REJ      = 6'b000001;
  localparam logic [5:0] P_LOGOUT   = 6'b000010;
  localparam logic [5:0] P_LOAD     = 6'b010000;

  localparam logic [2:0] S_IDLE = 3'd0, S_ACT = 3'd1, S_RSD = 3'd2, S_REC = 3'd3, S_FATAL = 3'd4;

  typedef struct {
    logic [5:0]    pul;
    logic [SW-1:0] val;
    int            due;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stand-in for the sequence generator
  logic          gen_set = 1'b0;
  logic [SW-1:0] gen_set_val = '0;
  logic [SW-1:0] gen_e = '0;
  assign expected_seq_i = gen_e;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst)               gen_e <= SW'(1);
    else if (gen_set)      gen_e <= gen_set_val;
    else if (seq_load_o)   gen_e <= seq_load_val_o;
    else if (seq_advance_o) gen_e <= gen_e + SW'(1);
  end

  always @(negedge clk) begin
    logic [5:0] p;
    exp_t       e;
    p = {seq_advance_o, seq_load_o, msg_accept_o, msg_ignore_o, logout_req_o, reject_o};
    if (p != 6'b0) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got pulses %b at cycle %0d, none expected", p, cyc);
      end else begin
        e = sb.pop_front();
        if (p !== e.pul || (e.pul[4] && seq_load_val_o !== e.val) || cyc != e.due) begin
          n_fail++;
          $display("FAIL decision: got pulses %b load_val %0d cycle %0d, expected %b load_val %0d cycle %0d",
                   p, seq_load_val_o, cyc, e.pul, e.val, e.due);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input logic [5:0] pul, input logic [SW-1:0] val, input int due);
    exp_t e;
    e.pul = pul; e.val = val; e.due = due;
    sb.push_back(e);
  endtask

  task automatic set_e(input logic [SW-1:0] v);
    @(negedge clk); gen_set = 1'b1; gen_set_val = v;
    @(negedge clk); gen_set = 1'b0;
  endtask

  task automatic send(input logic [3:0] mt, input logic [SW-1:0] s, input logic pd,
                      input logic gf, input logic [SW-1:0] nw,
                      input logic [5:0] pul, input logic [SW-1:0] lval, input logic [2:0] st);
    @(negedge clk);
    chk("hdr_ready_before_send", int'(hdr_ready_o), 1);
    hdr_valid_i = 1'b1; msg_type_i = mt; msg_seq_num_i = s;
    poss_dup_i = pd; gap_fill_i = gf; new_seq_num_i = nw;
    push(pul, lval, cyc + 2);
    @(negedge clk);
    hdr_valid_i = 1'b0;
    chk("hdr_ready_while_pending", int'(hdr_ready_o), 0);
    @(negedge clk);
    chk("state_after_decision", int'(state_o), int'(st));
  endtask

  // From ACTIVE with E forced to 5, message 9 opens gap 5..8 and then gets acked
  task automatic open_gap(input int hold);
    set_e(SW'(5));
    send(MT_APP, 8'd9, 1'b0, 1'b0, 8'd0, P_IGN, 8'd0, S_RSD);
    chk("rsd_valid_set", int'(rsd_valid_o), 1);
    chk("rsd_begin", int'(rsd_begin_o), 5);
    chk("rsd_end", int'(rsd_end_o), 8);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("rsd_valid_held", int'(rsd_valid_o), 1);
      chk("rsd_begin_held", int'(rsd_begin_o), 5);
      chk("rsd_end_held", int'(rsd_end_o), 8);
      chk("hdr_ready_in_rsd", int'(hdr_ready_o), 0);
    end
    rsd_ready_i = 1'b1;
    @(negedge clk);
    rsd_ready_i = 1'b0;
    chk("rsd_valid_dropped", int'(rsd_valid_o), 0);
    chk("state_recover", int'(state_o), int'(S_REC));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", int'(state_o), int'(S_IDLE));
    chk("reset_ready", int'(hdr_ready_o), 1);
    chk("reset_rsd_valid", int'(rsd_valid_o), 0);
    chk("reset_rsd_begin", int'(rsd_begin_o), 0);
    chk("reset_rsd_end", int'(rsd_end_o), 0);
    chk("reset_load_val", int'(seq_load_val_o), 0);
    chk("reset_pulses", int'({seq_advance_o, seq_load_o, msg_accept_o, msg_ignore_o, logout_req_o, reject_o}), 0);

    // Logon then in-order application message
    send(MT_LOGON, 8'd1, 1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_ACT);
    send(MT_APP,   8'd2, 1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_ACT);

    // Gap 5..8, held request, then fill in order
    open_gap(3);
    send(MT_APP, 8'd5, 1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_REC);
    send(MT_APP, 8'd6, 1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_REC);
    send(MT_APP, 8'd7, 1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_REC);
    send(MT_APP, 8'd8, 1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_ACT);

    // Gap-fill SequenceReset in RECOVER: valid jump, then backwards (rejected)
    open_gap(0);
    send(MT_SEQ_RESET, 8'd5, 1'b0, 1'b1, 8'd9, P_LOAD_ACC, 8'd9, S_ACT);
    open_gap(0);
    send(MT_SEQ_RESET, 8'd5, 1'b0, 1'b1, 8'd4, P_REJ_IGN, 8'd0, S_REC);

    // Reset-mode SequenceReset: leave RECOVER, equal boundary, then backwards
    send(MT_SEQ_RESET, 8'd77, 1'b0, 1'b0, 8'd10, P_LOAD_ACC, 8'd10, S_ACT);
    send(MT_SEQ_RESET, 8'd3,  1'b0, 1'b0, 8'd10, P_LOAD_ACC, 8'd10, S_ACT);
    send(MT_SEQ_RESET, 8'd3,  1'b0, 1'b0, 8'd3,  P_REJ,      8'd0,  S_ACT);

    // Too-low sequence numbers with and without PossDup
    send(MT_APP, 8'd7,  1'b1, 1'b0, 8'd0, P_IGN,    8'd0, S_ACT);
    send(MT_APP, 8'd7,  1'b0, 1'b0, 8'd0, P_LOGOUT, 8'd0, S_FATAL);
    send(MT_APP, 8'd10, 1'b0, 1'b0, 8'd0, P_IGN,    8'd0, S_FATAL);

    // Session reset arriving in the decision cycle of a pending event
    @(negedge clk);
    chk("hdr_ready_fatal", int'(hdr_ready_o), 1);
    hdr_valid_i = 1'b1; msg_type_i = MT_APP; msg_seq_num_i = 8'd10;
    @(negedge clk);
    hdr_valid_i = 1'b0; session_reset_i = 1'b1;
    push(P_LOAD, 8'd1, cyc + 1);
    @(negedge clk);
    session_reset_i = 1'b0;
    chk("state_after_session_reset", int'(state_o), int'(S_IDLE));
    send(MT_APP, 8'd1, 1'b0, 1'b0, 8'd0, P_IGN, 8'd0, S_IDLE);

    // Wrap of the expected number, then Logout and a fresh Logon
    send(MT_LOGON, 8'd1, 1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_ACT);
    set_e(8'd255);
    send(MT_APP,    8'd255, 1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_ACT);
    send(MT_APP,    8'd0,   1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_ACT);
    send(MT_LOGOUT, 8'd1,   1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_IDLE);
    send(MT_LOGON,  8'd2,   1'b0, 1'b0, 8'd0, P_ACC_ADV, 8'd0, S_ACT);

    // Hard reset while a ResendRequest is outstanding
    send(MT_APP, 8'd7, 1'b0, 1'b0, 8'd0, P_IGN, 8'd0, S_RSD);
    chk("rsd_begin_before_rst", int'(rsd_begin_o), 3);
    chk("rsd_end_before_rst", int'(rsd_end_o), 6);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rsd_valid", int'(rsd_valid_o), 0);
    chk("rst_state", int'(state_o), int'(S_IDLE));
    chk("rst_rsd_begin", int'(rsd_begin_o), 0);
    chk("rst_ready", int'(hdr_ready_o), 1);
    rst = 1'b0;

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
